// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared widths and the round/saturate helper for FIR consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int FIR_IN_W   = 31;
    localparam int FIR_OUT_W  = 16;
    localparam int FIR_CALC_W = 64;

    typedef struct packed {
        logic                         clip;
        logic signed [FIR_CALC_W-1:0] value;
    } sat_res_t;

    // Round-half-up then clip to a signed out_w range. The caller keeps the
    // low out_w bits of value; the sign-extended input must be narrower than
    // FIR_CALC_W so the rounding add cannot wrap.
    function automatic sat_res_t sat_round(
        input logic signed [FIR_CALC_W-1:0] value,
        input int unsigned                  shift,
        input int unsigned                  out_w
    );
        logic signed [FIR_CALC_W-1:0] rnd;
        logic signed [FIR_CALC_W-1:0] hi;
        logic signed [FIR_CALC_W-1:0] lo;
        sat_res_t                     res;
        rnd = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        res.clip  = 1'b0;
        res.value = rnd;
        if (rnd > hi) begin
            res.clip  = 1'b1;
            res.value = hi;
        end else if (rnd < lo) begin
            res.clip  = 1'b1;
            res.value = lo;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_result_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : First-word-fall-through FIFO with push-on-full-when-popping.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_rd_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(DEPTH):0]     o_count_next,
    output logic                       o_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign w_push_ok = i_push & (~w_full | w_pop);

    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_rd_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_rd_valid   = ~w_empty;
    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_drop       = i_push & w_full & ~w_pop;

endmodule
`default_nettype wire

// File: rtl/fir_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : fir_result_reader
// Description : Rounds/saturates FIR results, buffers them, back-pressures FIR.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_result_reader
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = 11,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [IN_W-1:0]          i_result,
    input  logic                     i_data_valid,
    output logic                     o_ce,
    output logic [OUT_W-1:0]         o_rd_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_sat,
    output logic                     o_overflow,
    input  logic                     i_clr_flags
);

    localparam int              CW          = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   C_CE_THRESH = CW'(DEPTH - 3);

    logic signed [FIR_CALC_W-1:0] w_ext;
    sat_res_t                     w_conv;
    logic                         w_unused;
    logic [OUT_W-1:0]             r_s1_data;
    logic                         r_s1_valid;
    logic                         r_ce;
    logic                         r_sat;
    logic                         r_overflow;
    logic [CW-1:0]                w_count_next;
    logic                         w_drop;

    assign w_ext    = {{(FIR_CALC_W-IN_W){i_result[IN_W-1]}}, i_result};
    assign w_conv   = sat_round(w_ext, SHIFT, OUT_W);
    assign w_unused = ^{w_conv.value[FIR_CALC_W-1:OUT_W]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_sat      <= 1'b0;
            r_overflow <= 1'b0;
            r_ce       <= 1'b1;
        end else begin
            r_s1_valid <= i_data_valid;
            if (i_data_valid) r_s1_data <= w_conv.value[OUT_W-1:0];
            // Set events take priority over a coincident clear.
            r_sat      <= (i_data_valid & w_conv.clip) | (r_sat & ~i_clr_flags);
            r_overflow <= w_drop | (r_overflow & ~i_clr_flags);
            // Headroom for the stage-1 sample plus one late FIR output.
            r_ce       <= (w_count_next <= C_CE_THRESH);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push       (r_s1_valid),
        .i_push_data  (r_s1_data),
        .i_pop        (i_rd_ready),
        .o_rd_data    (o_rd_data),
        .o_rd_valid   (o_rd_valid),
        .o_count      (o_count),
        .o_count_next (w_count_next),
        .o_drop       (w_drop)
    );

    assign o_ce       = r_ce;
    assign o_sat      = r_sat;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fir_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_result_reader
// Description : Directed self-checking bench for fir_result_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_result_reader;

    localparam int IN_W  = 31;
    localparam int OUT_W = 16;
    localparam int DEPTH = 8;

    logic                     clk;
    logic                     rst;
    logic [IN_W-1:0]          result;
    logic                     data_valid;
    logic                     ce;
    logic signed [OUT_W-1:0]  rd_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [3:0]               count;
    logic                     sat;
    logic                     overflow;
    logic                     clr_flags;

    int n_vec;
    int n_err;

    fir_result_reader #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (11),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_result     (result),
        .i_data_valid (data_valid),
        .o_ce         (ce),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid),
        .i_rd_ready   (rd_ready),
        .o_count      (count),
        .o_sat        (sat),
        .o_overflow   (overflow),
        .i_clr_flags  (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; data_valid = 1'b0; rd_ready = 1'b0; clr_flags = 1'b0; result = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (count !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 16'sd0) begin
            n_err++;
            $display("FAIL reset_fifo: count=%0d valid=%b data=%0d required 0/0/0", count, rd_valid, rd_data);
        end
        n_vec++;
        if (sat !== 1'b0 || overflow !== 1'b0 || ce !== 1'b1) begin
            n_err++;
            $display("FAIL reset_flags: sat=%b ovf=%b ce=%b required 0/0/1", sat, overflow, ce);
        end
    endtask

    task automatic test_impulse();
        rd_ready = 1'b1;
        result = 31'd2048; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++; $display("FAIL impulse_early: rd_valid=%b required 0", rd_valid);
        end
        tick();
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== 16'sd1) begin
            n_err++; $display("FAIL impulse_out: valid=%b data=%0d required 1/1", rd_valid, rd_data);
        end
        tick();
        n_vec++;
        if (rd_valid !== 1'b0 || sat !== 1'b0) begin
            n_err++; $display("FAIL impulse_after: valid=%b sat=%b required 0/0", rd_valid, sat);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_rounding();
        int                      ins  [5] = '{1023, 1024, -1024, -1025, 3071};
        logic signed [OUT_W-1:0] outs [5] = '{16'sd0, 16'sd1, 16'sd0, -16'sd1, 16'sd1};
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            result = IN_W'(ins[i]); data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        tick(); tick();
        n_vec++;
        if (count !== 4'd5) begin
            n_err++; $display("FAIL round_count: count=%0d required 5", count);
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (rd_valid !== 1'b1 || rd_data !== outs[i]) begin
                n_err++; $display("FAIL round_%0d: data=%0d valid=%b required %0d", i, rd_data, rd_valid, outs[i]);
            end
            rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        end
        n_vec++;
        if (sat !== 1'b0) begin
            n_err++; $display("FAIL round_nosat: sat=%b required 0", sat);
        end
    endtask

    task automatic test_saturation();
        rd_ready = 1'b0;
        result = 31'h3FFF_FFFF; data_valid = 1'b1; tick();
        result = 31'h4000_0000; tick();
        data_valid = 1'b0;
        tick(); tick();
        n_vec++;
        if (sat !== 1'b1) begin
            n_err++; $display("FAIL sat_flag: sat=%b required 1", sat);
        end
        n_vec++;
        if (rd_data !== 16'sd32767) begin
            n_err++; $display("FAIL sat_pos: data=%0d required 32767", rd_data);
        end
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        n_vec++;
        if (rd_data !== -16'sd32768) begin
            n_err++; $display("FAIL sat_neg: data=%0d required -32768", rd_data);
        end
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        n_vec++;
        if (sat !== 1'b0 || count !== 4'd0) begin
            n_err++; $display("FAIL sat_clear: sat=%b count=%0d required 0/0", sat, count);
        end
    endtask

    task automatic test_backpressure();
        int   exp_q[$];
        int   k        = 1;
        int   maxc     = 0;
        logic ce_q     = 1'b1;
        logic ce_bad   = 1'b0;
        logic saw_low  = 1'b0;
        int   n;
        rd_ready = 1'b0;
        // Source reacts to o_ce one cycle late, like a registered FIR output.
        for (int c = 0; c < 30; c++) begin
            data_valid = ce_q;
            if (ce_q) begin
                result = IN_W'(k * 2048); exp_q.push_back(k); k++;
            end
            ce_q = ce;
            tick();
            if (count >= 4'(DEPTH - 2) && ce !== 1'b0) ce_bad = 1'b1;
            if (ce === 1'b0) saw_low = 1'b1;
            if (int'(count) > maxc) maxc = int'(count);
        end
        data_valid = 1'b0;
        tick(); tick();
        n_vec++;
        if (ce_bad !== 1'b0 || saw_low !== 1'b1) begin
            n_err++; $display("FAIL bp_ce: ce_high_at_threshold=%b ce_fell=%b required 0/1", ce_bad, saw_low);
        end
        n_vec++;
        if (maxc > DEPTH || maxc < DEPTH - 2 || overflow !== 1'b0) begin
            n_err++; $display("FAIL bp_occupancy: max=%0d ovf=%b required %0d..%0d/0", maxc, overflow, DEPTH - 2, DEPTH);
        end
        n_vec++;
        if (int'(count) != exp_q.size()) begin
            n_err++; $display("FAIL bp_count: count=%0d required %0d", count, exp_q.size());
        end
        n = exp_q.size();
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (rd_valid !== 1'b1 || int'(rd_data) != exp_q[i]) begin
                n_err++; $display("FAIL bp_drain_%0d: data=%0d valid=%b required %0d", i, rd_data, rd_valid, exp_q[i]);
            end
            tick();
        end
        n_vec++;
        if (rd_valid !== 1'b0 || ce !== 1'b1) begin
            n_err++; $display("FAIL bp_empty: valid=%b ce=%b required 0/1", rd_valid, ce);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        rd_ready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            result = IN_W'(k * 2048); data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        tick(); tick();
        n_vec++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_state: count=%0d ovf=%b required 8/1", count, overflow);
        end
        rd_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            n_vec++;
            if (rd_valid !== 1'b1 || int'(rd_data) != k) begin
                n_err++; $display("FAIL ovf_drain_%0d: data=%0d valid=%b required %0d", k, rd_data, rd_valid, k);
            end
            tick();
        end
        rd_ready = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++; $display("FAIL ovf_extra: valid=%b required 0", rd_valid);
        end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_clear: ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            result = IN_W'(k * 2048); data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        tick(); tick();
        result = IN_W'(9 * 2048); data_valid = 1'b1;
        tick();
        data_valid = 1'b0; rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        n_vec++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
            n_err++; $display("FAIL fpp_state: count=%0d ovf=%b required 8/0", count, overflow);
        end
        rd_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            n_vec++;
            if (rd_valid !== 1'b1 || int'(rd_data) != k) begin
                n_err++; $display("FAIL fpp_drain_%0d: data=%0d valid=%b required %0d", k, rd_data, rd_valid, k);
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int k = 1; k <= 3; k++) begin
            result = IN_W'(k * 2048); data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++;
        if (count !== 4'd0 || rd_valid !== 1'b0 || ce !== 1'b1) begin
            n_err++; $display("FAIL midrst: count=%0d valid=%b ce=%b required 0/0/1", count, rd_valid, ce);
        end
        tick();
        n_vec++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_inflight: count=%0d valid=%b required 0/0", count, rd_valid);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; data_valid = 1'b0; rd_ready = 1'b0; clr_flags = 1'b0; result = '0;
        test_reset();
        test_impulse();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_result_reader.md
Name: fir_result_reader

Overview:
- Consumer for the generic FIR output stream: captures o_result/o_data_valid words, rounds and saturates them to a narrow output width, and buffers them in a small FIFO.
- Presents a ready/valid read port to the accelerator-side bus logic.
- Drives the FIR clock-enable as back-pressure so that no results are lost under normal operation.
- Sits between genericfir and the peripheral register/stream interface.

Parameters:
- IN_W, 31, width of signed FIR result input.
- OUT_W, 16, width of signed output sample.
- SHIFT, 11, right-shift (fractional bits) applied before saturation; must satisfy 1 <= SHIFT < IN_W.
- DEPTH, 8, FIFO entries; power of two, >= 4.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_result  in  IN_W  signed FIR result (connects to FIR o_result).
- i_data_valid  in  1  result qualifier (connects to FIR o_data_valid).
- o_ce  out  1  clock-enable to FIR (connects to FIR i_ce); low = stall.
- o_rd_data  out  OUT_W  signed head-of-FIFO sample.
- o_rd_valid  out  1  FIFO non-empty.
- i_rd_ready  in  1  consumer accepts o_rd_data this cycle.
- o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- o_sat  out  1  sticky: at least one sample saturated since last clear.
- o_overflow  out  1  sticky: at least one sample dropped since last clear.
- i_clr_flags  in  1  clears o_sat and o_overflow.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO empty: o_count=0, o_rd_valid=0, o_rd_data=0.
  - o_sat=0, o_overflow=0, o_ce=1.
  - Conversion stage valid bit cleared.
  - Reset mid-operation discards all buffered and in-flight samples.
- Stage 1 (conversion register):
  - When i_data_valid=1: r = (i_result + 2^(SHIFT-1)) >>> SHIFT, using arithmetic shift and a 1-bit-wider intermediate, so the rounding add never wraps. This is round-half-up.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register the saturated value plus a valid bit. Set o_sat the next cycle if clipping occurred.
- Stage 2 (FIFO write):
  - A stage-1 valid sample is written into the FIFO in the cycle after capture.
  - Total latency from i_data_valid to o_rd_valid on an empty FIFO is 2 cycles.
- FIFO behaviour:
  - First-word-fall-through: o_rd_data is valid whenever o_rd_valid=1.
  - Pop occurs when o_rd_valid & i_rd_ready.
  - Pointers wrap modulo DEPTH.
- Push/pop rules:
  - Push is accepted if not full, or if a pop happens in the same cycle; occupancy is then unchanged.
  - Push when full with no pop: the sample is dropped and o_overflow is set; FIFO contents are unchanged.
  - Pop when empty is ignored.
- Back-pressure:
  - o_ce is registered: o_ce <= (o_count_next <= DEPTH-3).
  - This leaves headroom for one in-flight stage-1 sample plus one sample the FIR may emit in the cycle o_ce falls.
  - With a compliant FIR, overflow must never occur.
- Flags:
  - o_sat and o_overflow are sticky.
  - When i_clr_flags coincides with a new set event, the set wins.
- o_count reflects post-update occupancy each cycle.

Decomposition:
- Shared package fir_pkg holds:
  - localparams FIR_IN_W=31 and FIR_OUT_W=16.
  - A function sat_round(value, shift) returning OUT_W bits plus a clip flag, reused by other FIR consumers.
- One sub-module, sync_fifo_fwft (parameters WIDTH, DEPTH), provides the storage, pointers and count. Top level holds the conversion stage, back-pressure and flags.

Test Plan:
- Impulse with SHIFT=11, i_rd_ready=1: i_result=2048, valid one cycle -> o_rd_data=1 with o_rd_valid high exactly 2 cycles later for 1 cycle; o_sat=0.
- Rounding: inputs 1023, 1024, -1024, -1025, 3071 -> outputs 0, 1, 0, -1, 1 in order.
- Saturation: inputs 2^30-1 and -2^30 -> 32767 and -32768; o_sat=1. After pulsing i_clr_flags, o_sat=0.
- Back-pressure: i_rd_ready=0 with continuous valid input.
  - o_ce must fall once o_count reaches DEPTH-2.
  - Occupancy settles at <= DEPTH; o_overflow stays 0.
  - Raising i_rd_ready drains all samples in order, with no loss or duplication.
- Forced overflow: ignore o_ce, drive 12 consecutive valid samples (values 1..12 scaled by 2048) with i_rd_ready=0.
  - FIFO holds 1..8; o_overflow=1.
  - Draining yields exactly 1..8.
- Full with simultaneous push/pop: FIFO full, i_rd_ready=1, and a new valid sample arrives.
  - Count stays DEPTH, no overflow, order preserved.
  - A mid-stream i_reset pulse -> o_count=0, o_rd_valid=0, o_ce=1 on the next cycle.
